// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of pipeline-control handshake signals between the hazard/EX logic and
// the stall controller. The controller takes the slave view.
interface pipe_stall_ctrl_if #(
  parameter int LEN_W = 6
);
  logic             stallreq_id_i;
  logic             mc_req_i;
  logic             mc_ext_i;
  logic [LEN_W-1:0] mc_len_i;
  logic             mc_done_i;
  logic             flush_i;
  logic [5:0]       stall_o;
  logic [LEN_W-1:0] mc_cnt_o;
  logic             mc_start_o;
  logic             mc_annul_o;
  logic             busy_o;

  modport master (
    output stallreq_id_i, mc_req_i, mc_ext_i, mc_len_i, mc_done_i, flush_i,
    input  stall_o, mc_cnt_o, mc_start_o, mc_annul_o, busy_o
  );

  modport slave (
    input  stallreq_id_i, mc_req_i, mc_ext_i, mc_len_i, mc_done_i, flush_i,
    output stall_o, mc_cnt_o, mc_start_o, mc_annul_o, busy_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: merges the ID load-use stall with EX multi-cycle
// operations (internally counted or externally completed) into one stall vector.
module pipe_stall_ctrl #(
  parameter int LEN_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  ctrl
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_INT = 2'd1,
    RUN_EXT = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] eff_len;
  logic             ex_stall;
  logic             start_pulse;
  logic             annul_pulse;
  logic [5:0]       stall_vec;

  // A zero length is treated as a single-cycle op.
  assign eff_len = (ctrl.mc_len_i == '0) ? CNT_ONE : ctrl.mc_len_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ex_stall    = 1'b0;
    start_pulse = 1'b0;
    annul_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl.mc_req_i) begin
          if (ctrl.mc_ext_i) begin
            if (ctrl.flush_i) begin
              annul_pulse = 1'b1;
            end else begin
              start_pulse = 1'b1;
              ex_stall    = 1'b1;
              cnt_d       = CNT_ONE;
              state_d     = RUN_EXT;
            end
          end else if (!ctrl.flush_i && (eff_len != CNT_ONE)) begin
            len_d    = eff_len;
            cnt_d    = CNT_ONE;
            ex_stall = 1'b1;
            state_d  = RUN_INT;
          end
        end
      end
      RUN_INT: begin
        if (ctrl.flush_i || (cnt_q == len_q - CNT_ONE)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      RUN_EXT: begin
        // Flush outranks a coincident done: the result is dropped and the unit aborted.
        if (ctrl.flush_i) begin
          annul_pulse = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (ctrl.mc_done_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          ex_stall = 1'b1;
          cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // PC/IF/ID hold on either request, EX only on its own, MEM/WB never hold.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_stall
      if (gi < 3) begin : g_front
        assign stall_vec[gi] = ex_stall | ctrl.stallreq_id_i;
      end else if (gi == 3) begin : g_ex
        assign stall_vec[gi] = ex_stall;
      end else begin : g_back
        assign stall_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign ctrl.stall_o    = rst ? 6'b000000 : stall_vec;
  assign ctrl.mc_cnt_o   = (rst || state_q == IDLE) ? '0 : cnt_q;
  assign ctrl.mc_start_o = ~rst & start_pulse;
  assign ctrl.mc_annul_o = ~rst & annul_pulse;
  assign ctrl.busy_o     = ~rst & (state_q != IDLE);

  a_start_annul_excl: assert property (@(posedge clk) disable iff (rst)
    !(ctrl.mc_start_o && ctrl.mc_annul_o));
  a_back_never_held: assert property (@(posedge clk) disable iff (rst)
    ctrl.stall_o[5:4] == 2'b00);
  a_start_enters_ext: assert property (@(posedge clk) disable iff (rst)
    ctrl.mc_start_o |=> (state_q == RUN_EXT));
  a_int_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN_INT) |-> (cnt_q < len_q));

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: an op-level model checked every cycle,
// plus literal per-cycle expectations that pin the model.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_stall_ctrl_if #(.LEN_W(6)) bus ();

  pipe_stall_ctrl #(.LEN_W(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  // literal expectation for the current cycle, set by the stimulus
  bit         lit_on = 1'b0;
  string      lit_name = "";
  logic [5:0] lit_stall, lit_cnt;
  bit         lit_busy, lit_start, lit_annul;

  // op-level model: 0 = no op in EX, 1 = counted op, 2 = external op
  int m_mode = 0;
  int m_pos = 0;
  int m_total = 0;

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc_no, act, exp);
    end
  endtask

  initial begin
    logic [5:0] e_stall, e_cnt;
    bit e_start, e_annul, e_busy, ex;
    int eff;
    forever begin
      @(negedge clk);
      cyc_no++;
      eff = (bus.mc_len_i == 0) ? 1 : int'(bus.mc_len_i);
      if (rst) begin
        e_stall = '0; e_cnt = '0; e_start = 0; e_annul = 0; e_busy = 0;
      end else begin
        case (m_mode)
          1:       ex = (m_total - m_pos) > 1;
          2:       ex = !bus.mc_done_i;
          default: ex = bus.mc_req_i && (bus.mc_ext_i || eff > 1);
        endcase
        if (bus.flush_i) ex = 0;
        e_stall = ex ? 6'b001111 : (bus.stallreq_id_i ? 6'b000111 : 6'b000000);
        e_start = (m_mode == 0) && bus.mc_req_i && bus.mc_ext_i && !bus.flush_i;
        e_annul = bus.flush_i && ((m_mode == 2) || ((m_mode == 0) && bus.mc_req_i && bus.mc_ext_i));
        e_cnt   = (m_mode == 0) ? 6'd0 : m_pos[5:0];
        e_busy  = (m_mode != 0);
      end
      chk("model stall_o", bus.stall_o, e_stall);
      chk("model mc_cnt_o", bus.mc_cnt_o, e_cnt);
      chk("model mc_start_o", {5'b0, bus.mc_start_o}, {5'b0, e_start});
      chk("model mc_annul_o", {5'b0, bus.mc_annul_o}, {5'b0, e_annul});
      chk("model busy_o", {5'b0, bus.busy_o}, {5'b0, e_busy});
      if (lit_on) begin
        chk({lit_name, " stall_o"}, bus.stall_o, lit_stall);
        chk({lit_name, " mc_cnt_o"}, bus.mc_cnt_o, lit_cnt);
        chk({lit_name, " busy_o"}, {5'b0, bus.busy_o}, {5'b0, lit_busy});
        chk({lit_name, " mc_start_o"}, {5'b0, bus.mc_start_o}, {5'b0, lit_start});
        chk({lit_name, " mc_annul_o"}, {5'b0, bus.mc_annul_o}, {5'b0, lit_annul});
      end
      // advance the model across the coming edge
      if (rst || bus.flush_i) begin
        m_mode = 0; m_pos = 0;
      end else begin
        case (m_mode)
          0: if (bus.mc_req_i && bus.mc_ext_i) begin
               m_mode = 2; m_pos = 1;
             end else if (bus.mc_req_i && eff > 1) begin
               m_mode = 1; m_pos = 1; m_total = eff;
             end
          1: begin
               m_pos++;
               if (m_pos == m_total) begin m_mode = 0; m_pos = 0; end
             end
          default: if (bus.mc_done_i) begin
                     m_mode = 0; m_pos = 0;
                   end else if (m_pos < 63) begin
                     m_pos++;
                   end
        endcase
      end
    end
  end

  task automatic cyc(input bit sid, input bit req, input bit ext, input logic [5:0] len,
                     input bit done, input bit fl);
    @(posedge clk);
    #1;
    bus.stallreq_id_i = sid;
    bus.mc_req_i      = req;
    bus.mc_ext_i      = ext;
    bus.mc_len_i      = len;
    bus.mc_done_i     = done;
    bus.flush_i       = fl;
    lit_on            = 1'b0;
  endtask

  task automatic want(input string nm, input logic [5:0] st, input logic [5:0] cn,
                      input bit bz, input bit sp, input bit an);
    lit_on = 1'b1; lit_name = nm; lit_stall = st; lit_cnt = cn;
    lit_busy = bz; lit_start = sp; lit_annul = an;
  endtask

  initial begin
    bus.stallreq_id_i = 0; bus.mc_req_i = 0; bus.mc_ext_i = 0;
    bus.mc_len_i = '0; bus.mc_done_i = 0; bus.flush_i = 0;

    // outputs stay quiet under reset even with active inputs
    cyc(1, 1, 1, 6'd5, 1, 0); want("rst_hold", 6'b0, 6'd0, 0, 0, 0);
    cyc(1, 1, 0, 6'd3, 0, 1); want("rst_hold2", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); rst = 0; want("idle", 6'b0, 6'd0, 0, 0, 0);

    cyc(1, 0, 0, 6'd0, 0, 0); want("id_stall", 6'b000111, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("id_release", 6'b0, 6'd0, 0, 0, 0);

    cyc(0, 1, 0, 6'd2, 0, 0); want("int2_c0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("int2_c1", 6'b0, 6'd1, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("int2_idle", 6'b0, 6'd0, 0, 0, 0);

    cyc(0, 1, 0, 6'd0, 0, 0); want("len0", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 1, 0, 6'd1, 0, 0); want("len1", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 1, 0); want("done_in_idle", 6'b0, 6'd0, 0, 0, 0);

    cyc(0, 1, 1, 6'd0, 0, 0); want("ext_c0", 6'b001111, 6'd0, 0, 1, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 1, 1, 6'd0, 0, 0);
      if (k == 1)  want("ext_c1", 6'b001111, 6'd1, 1, 0, 0);
      if (k == 32) want("ext_c32", 6'b001111, 6'd32, 1, 0, 0);
    end
    cyc(0, 1, 1, 6'd0, 1, 0); want("ext_done", 6'b0, 6'd33, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("ext_after", 6'b0, 6'd0, 0, 0, 0);

    // back-to-back counted ops, no gap cycle
    cyc(0, 1, 0, 6'd3, 0, 0); want("b2b_a0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(0, 1, 0, 6'd3, 0, 0); want("b2b_a1", 6'b001111, 6'd1, 1, 0, 0);
    cyc(0, 1, 0, 6'd3, 0, 0); want("b2b_a2", 6'b0, 6'd2, 1, 0, 0);
    cyc(0, 1, 0, 6'd2, 0, 0); want("b2b_b0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("b2b_b1", 6'b0, 6'd1, 1, 0, 0);

    cyc(0, 1, 1, 6'd0, 0, 0); want("xf_c0", 6'b001111, 6'd0, 0, 1, 0);
    cyc(0, 1, 1, 6'd0, 0, 0); want("xf_c1", 6'b001111, 6'd1, 1, 0, 0);
    cyc(1, 1, 1, 6'd0, 1, 1); want("ext_flush_done", 6'b000111, 6'd2, 1, 0, 1);
    cyc(0, 0, 0, 6'd0, 0, 0); want("ext_flush_idle", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 1, 1, 6'd0, 0, 1); want("idle_flush_ext", 6'b0, 6'd0, 0, 0, 1);
    cyc(0, 0, 0, 6'd0, 0, 0); want("idle_flush_after", 6'b0, 6'd0, 0, 0, 0);

    cyc(0, 1, 0, 6'd4, 0, 0); want("int4_c0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(1, 0, 0, 6'd0, 0, 0); want("int4_id_c1", 6'b001111, 6'd1, 1, 0, 0);
    cyc(1, 0, 0, 6'd0, 0, 0); want("int4_id_c2", 6'b001111, 6'd2, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("int4_c3", 6'b0, 6'd3, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("int4_idle", 6'b0, 6'd0, 0, 0, 0);

    cyc(0, 1, 0, 6'd5, 0, 0); want("int5_c0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(1, 0, 0, 6'd0, 0, 1); want("int_flush", 6'b000111, 6'd1, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("int_flush_idle", 6'b0, 6'd0, 0, 0, 0);

    // asynchronous reset while the counted op sits at cnt=3
    cyc(0, 1, 0, 6'd6, 0, 0); want("ar_c0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("ar_c1", 6'b001111, 6'd1, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("ar_c2", 6'b001111, 6'd2, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0);
    #1 rst = 1; want("arst_now", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 1, 0, 6'd3, 0, 0); want("arst_hold", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); rst = 0; want("arst_release", 6'b0, 6'd0, 0, 0, 0);
    cyc(0, 1, 0, 6'd3, 0, 0); want("post_c0", 6'b001111, 6'd0, 0, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("post_c1", 6'b001111, 6'd1, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("post_c2", 6'b0, 6'd2, 1, 0, 0);
    cyc(0, 0, 0, 6'd0, 0, 0); want("post_idle", 6'b0, 6'd0, 0, 0, 0);

    // mixed traffic, checked by the model alone
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
          6'($urandom % 6), ($urandom % 6) == 0, ($urandom % 16) == 0);
    end
    cyc(0, 0, 0, 6'd0, 0, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
